// File: rtl/aes_package.sv
// Shared AES datapath types and helpers: word/block widths, the input
// assembler state encoding and a byte-granular word mask.
package aes_package;

    localparam int AES_WORD_W  = 32;
    localparam int AES_BLOCK_W = 128;

    typedef enum logic [1:0] {
        ASM_IDLE,
        ASM_FILL,
        ASM_HOLD,
        ASM_DONE
    } aes_asm_state_t;

    // Zero every byte whose index is >= nbytes; byte 0 is bits [7:0].
    function automatic logic [AES_WORD_W-1:0] aes_word_mask(input logic [AES_WORD_W-1:0] word,
                                                            input logic [2:0]            nbytes);
        logic [AES_WORD_W-1:0] r;
        r = word;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) >= nbytes) begin
                r[8*i +: 8] = 8'h00;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_block_assembler.sv
// Packs 32-bit streamer words into zero-padded 128-bit AES blocks (AES_ASM_BYTE_SWAP_EN: byte-reverse words).
// Latency: block valid the cycle after its closing word is accepted; done_o one cycle after the final handshake.
// Backpressure: in_ready_o is low while a block waits in HOLD; the block is held stable until blk_ready_i.
module aes_block_assembler
    import aes_package::*;
#(
    parameter int WORD_W  = AES_WORD_W,
    parameter int BLOCK_W = AES_BLOCK_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               start_i,
    input  logic [31:0]        byte_len_i,
    input  logic [WORD_W-1:0]  in_data_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    output logic [BLOCK_W-1:0] blk_data_o,
    output logic               blk_valid_o,
    input  logic               blk_ready_i,
    output logic               blk_last_o,
    output logic [4:0]         blk_bytes_o,
    output logic               busy_o,
    output logic               done_o
);

    aes_asm_state_t     state_q, state_d;
    logic [BLOCK_W-1:0] buf_q, buf_d;
    logic [31:0]        rem_q, rem_d;
    logic [1:0]         word_cnt_q, word_cnt_d;
    logic [4:0]         bytes_q, bytes_d;
    logic               last_q, last_d;

    logic [2:0]         take;
    logic [WORD_W-1:0]  word_in;

    always_comb begin
        take = (rem_q >= 32'd4) ? 3'd4 : rem_q[2:0];
`ifdef AES_ASM_BYTE_SWAP_EN
        word_in = {in_data_i[7:0], in_data_i[15:8], in_data_i[23:16], in_data_i[31:24]};
`else
        word_in = in_data_i;
`endif
    end

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        rem_d      = rem_q;
        word_cnt_d = word_cnt_q;
        bytes_d    = bytes_q;
        last_d     = last_q;

        unique case (state_q)
            ASM_IDLE: begin
                if (start_i) begin
                    if (byte_len_i != 32'd0) begin
                        rem_d      = byte_len_i;
                        buf_d      = '0;
                        word_cnt_d = 2'd0;
                        bytes_d    = 5'd0;
                        last_d     = 1'b0;
                        state_d    = ASM_FILL;
                    end else begin
                        state_d = ASM_DONE;
                    end
                end
            end
            ASM_FILL: begin
                if (in_valid_i) begin
                    buf_d[{word_cnt_q, 5'b0} +: WORD_W] = aes_word_mask(word_in, take);
                    rem_d      = rem_q - 32'(take);
                    word_cnt_d = word_cnt_q + 2'd1;
                    bytes_d    = bytes_q + 5'(take);
                    if (word_cnt_q == 2'd3 || rem_q <= 32'd4) begin
                        last_d  = (rem_q <= 32'd4);
                        state_d = ASM_HOLD;
                    end
                end
            end
            ASM_HOLD: begin
                if (blk_ready_i) begin
                    // The buffer is emptied either way so stale data never leaks out after the job.
                    buf_d      = '0;
                    word_cnt_d = 2'd0;
                    bytes_d    = 5'd0;
                    last_d     = 1'b0;
                    state_d    = last_q ? ASM_DONE : ASM_FILL;
                end
            end
            ASM_DONE: begin
                state_d = ASM_IDLE;
            end
            default: state_d = ASM_IDLE;
        endcase

        if (clear) begin
            state_d    = ASM_IDLE;
            buf_d      = '0;
            rem_d      = 32'd0;
            word_cnt_d = 2'd0;
            bytes_d    = 5'd0;
            last_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ASM_IDLE;
            buf_q      <= '0;
            rem_q      <= 32'd0;
            word_cnt_q <= 2'd0;
            bytes_q    <= 5'd0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            rem_q      <= rem_d;
            word_cnt_q <= word_cnt_d;
            bytes_q    <= bytes_d;
            last_q     <= last_d;
        end
    end

    assign in_ready_o  = (state_q == ASM_FILL);
    assign blk_valid_o = (state_q == ASM_HOLD);
    assign busy_o      = (state_q != ASM_IDLE);
    assign done_o      = (state_q == ASM_DONE);
    assign blk_data_o  = buf_q;
    assign blk_last_o  = last_q;
    assign blk_bytes_o = bytes_q;

endmodule

// File: tb/tb_aes_block_assembler.sv
// Randomized and directed bench for aes_block_assembler against a message-level reference model.
module tb_aes_block_assembler;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         clear = 1'b0;
    logic         start_i = 1'b0;
    logic [31:0]  byte_len_i = '0;
    logic [31:0]  in_data_i = '0;
    logic         in_valid_i = 1'b0;
    logic         in_ready_o;
    logic [127:0] blk_data_o;
    logic         blk_valid_o;
    logic         blk_ready_i = 1'b0;
    logic         blk_last_o;
    logic [4:0]   blk_bytes_o;
    logic         busy_o;
    logic         done_o;

    int vectors = 0;
    int errors  = 0;

    logic [31:0]  words [0:19];
    logic [127:0] cap [$];

    always #5 clk = ~clk;

    aes_block_assembler dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (clear),
        .start_i     (start_i),
        .byte_len_i  (byte_len_i),
        .in_data_i   (in_data_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .blk_data_o  (blk_data_o),
        .blk_valid_o (blk_valid_o),
        .blk_ready_i (blk_ready_i),
        .blk_last_o  (blk_last_o),
        .blk_bytes_o (blk_bytes_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Message byte j of the stored word: optional reversal, then keep the first n bytes.
    function automatic logic [31:0] ref_word(input logic [31:0] w, input int n);
        logic [31:0] s;
        logic [31:0] r;
`ifdef AES_ASM_BYTE_SWAP_EN
        s = {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        s = w;
`endif
        r = 32'd0;
        for (int b = 0; b < 4; b++) begin
            if (b < n) r[8*b +: 8] = s[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [127:0] ref_block(input int len, input int k);
        logic [127:0] blk;
        int i;
        int rem;
        blk = '0;
        for (int w = 0; w < 4; w++) begin
            i   = 4 * k + w;
            rem = len - 4 * i;
            if (rem > 0) blk[32*w +: 32] = ref_word(words[i], (rem > 4) ? 4 : rem);
        end
        return blk;
    endfunction

    task automatic run_job(input int len, input int stall, input bit rnd);
        int  nwords;
        int  nblk;
        int  widx;
        int  bidx;
        int  held;
        int  cyc;
        bit  seen_done;
        bit  prev_close;
        bit  prev_hs;
        bit  prev_last;
        bit  prev_last_hs;
        bit  prev_valid;
        bit  hs;
        bit  acc;
        int  bleft;
        logic [127:0] prev_data;
        nwords = (len + 3) / 4;
        nblk   = (len + 15) / 16;
        widx = 0; bidx = 0; held = 0; cyc = 0; seen_done = 0;
        prev_close = 0; prev_hs = 0; prev_last = 0; prev_valid = 0;
        prev_last_hs = (len == 0);
        prev_data = '0;
        cap.delete();
        @(negedge clk);
        start_i    = 1'b1;
        byte_len_i = len;
        @(negedge clk);
        start_i    = 1'b0;
        byte_len_i = $urandom;
        while (!seen_done && cyc < 3000) begin
            if (prev_close)            chk("valid_latency", {127'd0, blk_valid_o}, 128'd1);
            if (prev_hs && !prev_last) chk("next_ready", {127'd0, in_ready_o}, 128'd1);
            if (prev_last_hs)          chk("done_timing", {127'd0, done_o}, 128'd1);
            if (prev_valid && !prev_hs) chk("hold_stable", blk_data_o, prev_data);
            if (widx >= nwords)        chk("ready_after_words", {127'd0, in_ready_o}, 128'd0);
            if (blk_valid_o)           chk("no_ready_in_hold", {127'd0, in_ready_o}, 128'd0);
            if (done_o) begin
                seen_done = 1;
                chk("blocks_seen", 128'(bidx), 128'(nblk));
                chk("words_accepted", 128'(widx), 128'(nwords));
            end else begin
                if (blk_valid_o && bidx == 0 && held < stall) begin
                    blk_ready_i = 1'b0;
                    held++;
                end else begin
                    blk_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                hs = blk_valid_o && blk_ready_i;
                prev_last = 0;
                if (hs) begin
                    bleft = len - 16 * bidx;
                    chk("blk_data", blk_data_o, ref_block(len, bidx));
                    chk("blk_last", {127'd0, blk_last_o}, {127'd0, (bleft <= 16)});
                    chk("blk_bytes", {123'd0, blk_bytes_o}, 128'((bleft > 16) ? 16 : bleft));
                    prev_last = blk_last_o;
                    cap.push_back(blk_data_o);
                    bidx++;
                end
                in_valid_i = rnd ? 1'($urandom_range(0, 3) != 0) : 1'b1;
                in_data_i  = (widx < 20) ? words[widx] : $urandom;
                acc = in_valid_i && in_ready_o;
                prev_close = acc && (widx < nwords) && ((widx % 4 == 3) || (widx == nwords - 1));
                if (acc) widx++;
                prev_hs      = hs;
                prev_last_hs = hs && (bidx == nblk);
                prev_valid   = blk_valid_o;
                prev_data    = blk_data_o;
                @(negedge clk);
                cyc++;
            end
        end
        if (!seen_done) chk("job_timeout", 128'd0, 128'd1);
        in_valid_i  = 1'b0;
        blk_ready_i = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", {126'd0, done_o, busy_o}, 128'd0);
    endtask

    initial begin
        // Reset state
        #3;
        chk("reset_outputs", {blk_data_o, in_ready_o, blk_valid_o, blk_last_o, blk_bytes_o, busy_o, done_o}
                             >> 0, 128'd0);
        chk("reset_data", blk_data_o, 128'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Single full block with known byte pattern
        words[0] = 32'h03020100; words[1] = 32'h07060504;
        words[2] = 32'h0B0A0908; words[3] = 32'h0F0E0D0C;
        run_job(16, 0, 0);
`ifndef AES_ASM_BYTE_SWAP_EN
        chk("tp1_cap_n", 128'(cap.size()), 128'd1);
        if (cap.size() >= 1) chk("tp1_block", cap[0], 128'h0F0E0D0C_0B0A0908_07060504_03020100);
`endif

        // 21 bytes of ones, six words offered
        for (int i = 0; i < 20; i++) words[i] = 32'hFFFFFFFF;
        run_job(21, 0, 0);
        chk("tp2_cap_n", 128'(cap.size()), 128'd2);
        if (cap.size() >= 2) begin
            chk("tp2_block0", cap[0], {128{1'b1}});
            chk("tp2_block1", cap[1], 128'h00000000_00000000_000000FF_FFFFFFFF);
        end

        // Empty message
        run_job(0, 0, 1);
        chk("tp3_cap_n", 128'(cap.size()), 128'd0);

        // Two blocks, engine stalls ten cycles on the first
        for (int i = 0; i < 20; i++) words[i] = $urandom;
        run_job(32, 10, 0);

        // Clear mid-fill after two words
        @(negedge clk);
        start_i = 1'b1; byte_len_i = 32'd16;
        @(negedge clk);
        start_i = 1'b0; in_valid_i = 1'b1; in_data_i = 32'h11111111;
        @(negedge clk);
        in_data_i = 32'h22222222;
        @(negedge clk);
        in_valid_i = 1'b0; clear = 1'b1; start_i = 1'b1; byte_len_i = 32'd8;
        @(negedge clk);
        clear = 1'b0; start_i = 1'b0;
        chk("clr_state", {124'd0, busy_o, blk_valid_o, done_o, in_ready_o}, 128'd0);
        chk("clr_data", blk_data_o, 128'd0);
        @(negedge clk);
        chk("clr_no_done", {126'd0, done_o, busy_o}, 128'd0);
        words[0] = 32'hAABBCCDD;
        run_job(4, 0, 0);
        chk("tp5_cap_n", 128'(cap.size()), 128'd1);
`ifndef AES_ASM_BYTE_SWAP_EN
        if (cap.size() >= 1) chk("tp5_block", cap[0], {96'd0, 32'hAABBCCDD});
`endif

`ifdef AES_ASM_BYTE_SWAP_EN
        words[0] = 32'h44332211;
        run_job(3, 0, 0);
        if (cap.size() >= 1) chk("swap_word0", cap[0], {96'd0, 32'h00223344});
`endif

        // Random jobs with random valid/ready gaps
        for (int j = 0; j < 12; j++) begin
            for (int i = 0; i < 20; i++) words[i] = $urandom;
            run_job($urandom_range(1, 64), $urandom_range(0, 4), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
